blink_tx: RTL and testbench

Transmit-side LED pattern driver: converts single-cycle internal request pulses (such as the debounced one-shot from the button path) into a visible burst of N blinks on an active-low LED pin. It is the output end of the button-to-LED chain, so a bare one-shot can become a counted, human-readable indication. It provides a busy/done handshake and a one-deep request slot so back-to-back presses are not lost silently.

---
 rtl/blink_pkg.sv | 19 +
 rtl/blink_if.sv | 18 +
 rtl/blink_timer.sv | 28 ++
 rtl/blink_tx.sv | 142 ++++++++++++++
 tb/tb_blink_tx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types and sizing helpers for the blink_tx LED pattern driver.
package blink_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam int DEFAULT_ON_CYCLES  = 4;
  localparam int DEFAULT_OFF_CYCLES = 4;
  localparam int DEFAULT_CNT_W      = 4;

  // Width needed to hold the longer of the two phase lengths.
  function automatic int phase_width(input int on_c, input int off_c);
    int m;
    m = (on_c > off_c) ? on_c : off_c;
    return $clog2(m + 1);
  endfunction

  localparam int PH_W = phase_width(DEFAULT_ON_CYCLES, DEFAULT_OFF_CYCLES);

endpackage

// File: rtl/blink_if.sv
// Request/status bundle between a requester and the blink_tx driver.
interface blink_if
  import blink_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             req;
  logic [CNT_W-1:0] count;
  logic             led_n;
  logic             busy;
  logic             done;
  logic             dropped;

  modport master (output req, count, input led_n, busy, done, dropped);
  modport slave  (input req, count, output led_n, busy, done, dropped);

endinterface

// File: rtl/blink_timer.sv
// Loadable down-counter; tc is high once the count has reached zero.
module blink_timer
  import blink_pkg::*;
#(
  parameter int W = PH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/blink_tx.sv
// Turns single-cycle requests into N visible blinks on an active-low LED,
// with a one-deep pending-request slot and busy/done/dropped status.
module blink_tx
  import blink_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input logic   clk,
  input logic   rst,
  blink_if.slave bus
);

  localparam int TW = phase_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_param_check
    $error("blink_tx: ON_CYCLES and OFF_CYCLES must both be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] blinks_q, blinks_d;
  logic             slot_valid_q, slot_valid_d;
  logic [CNT_W-1:0] slot_count_q, slot_count_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;
  logic             timer_load;
  logic [TW-1:0]    timer_value;
  logic             timer_tc;
  logic             accept;
  logic             slot_req;

  blink_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_value),
    .tc        (timer_tc)
  );

  assign accept = bus.req && (bus.count != '0);

  always_comb begin
    state_d      = state_q;
    blinks_d     = blinks_q;
    slot_valid_d = slot_valid_q;
    slot_count_d = slot_count_q;
    done_d       = 1'b0;
    dropped_d    = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;
    slot_req     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ON;
          blinks_d    = bus.count;
          timer_load  = 1'b1;
          timer_value = ON_LOAD;
        end
      end
      ON: begin
        slot_req = accept;
        if (timer_tc) begin
          state_d     = OFF;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end
      OFF: begin
        // Last OFF cycle of the final blink: hand over to the slot or a fresh request.
        if (timer_tc && blinks_q <= CNT_W'(1)) begin
          done_d = 1'b1;
          if (slot_valid_q) begin
            state_d      = ON;
            blinks_d     = slot_count_q;
            timer_load   = 1'b1;
            timer_value  = ON_LOAD;
            slot_valid_d = accept;
            if (accept) begin
              slot_count_d = bus.count;
            end
          end else if (accept) begin
            state_d     = ON;
            blinks_d    = bus.count;
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          slot_req = accept;
          if (timer_tc) begin
            state_d     = ON;
            blinks_d    = blinks_q - CNT_W'(1);
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (slot_req) begin
      if (!slot_valid_q) begin
        slot_valid_d = 1'b1;
        slot_count_d = bus.count;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      blinks_q     <= '0;
      slot_valid_q <= 1'b0;
      slot_count_q <= '0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blinks_q     <= blinks_d;
      slot_valid_q <= slot_valid_d;
      slot_count_q <= slot_count_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.led_n   = (state_q != ON);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_blink_tx.sv
// Self-checking bench for blink_tx: directed scenarios plus random requests
// compared cycle by cycle against a timeline model of the blink schedule.
module tb_blink_tx;
  import blink_pkg::*;

  localparam int ON_C  = 4;
  localparam int OFF_C = 4;
  localparam int CW    = 4;
  localparam int P     = ON_C + OFF_C;

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_if #(.CNT_W(CW)) bus ();

  blink_tx #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: active sequence as (first ON cycle, blink count) plus a one-entry slot.
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_n      = 0;
  bit m_slot_v = 1'b0;
  int m_slot_n = 0;
  bit m_done   = 1'b0;
  bit m_drop   = 1'b0;

  int lit_cnt = 0;
  int done_q[$];
  int drop_q[$];

  task automatic modelStep(input bit r, input bit req, input int count, input int c);
    bit acc;
    acc    = req && (count != 0);
    m_done = 1'b0;
    m_drop = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_slot_v = 1'b0;
    end else if (m_active && c == m_start + m_n * P) begin
      m_done = 1'b1;
      if (m_slot_v) begin
        m_start  = c;
        m_n      = m_slot_n;
        m_slot_v = acc;
        if (acc) m_slot_n = count;
      end else if (acc) begin
        m_start = c;
        m_n     = count;
      end else begin
        m_active = 1'b0;
      end
    end else if (m_active) begin
      if (acc) begin
        if (!m_slot_v) begin
          m_slot_v = 1'b1;
          m_slot_n = count;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else if (acc) begin
      m_active = 1'b1;
      m_start  = c;
      m_n      = count;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic exp_led;
    exp_led = !(m_active && (((cyc - m_start) % P) < ON_C));
    checkBit("led_n",   bus.led_n,   exp_led);
    checkBit("busy",    bus.busy,    m_active);
    checkBit("done",    bus.done,    m_done);
    checkBit("dropped", bus.dropped, m_drop);
  endtask

  // One clock cycle: drive inputs for the current cycle, then check the next one.
  task automatic applyStimulus(input bit r, input bit req, input int count);
    @(negedge clk);
    rst       = r;
    bus.req   = req;
    bus.count = CW'(count);
    @(posedge clk);
    cyc++;
    modelStep(r, req, count, cyc);
    #1;
    if (bus.led_n === 1'b0) lit_cnt++;
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (bus.dropped === 1'b1) drop_q.push_back(cyc);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic clearStats();
    lit_cnt = 0;
    done_q.delete();
    drop_q.delete();
  endtask

  initial begin
    int base;
    bus.req   = 1'b0;
    bus.count = '0;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    idle(20);

    $display("[TB] single request of 3 blinks");
    clearStats();
    base = cyc;
    idle(10);
    applyStimulus(1'b0, 1'b1, 3);
    idle(30);
    checkInt("single_lit", lit_cnt, 12);
    checkInt("single_ndone", done_q.size(), 1);
    if (done_q.size() > 0) checkInt("single_done_cyc", done_q[0] - base, 35);

    $display("[TB] zero-count requests");
    clearStats();
    applyStimulus(1'b0, 1'b1, 0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 2);
    idle(2);
    applyStimulus(1'b0, 1'b1, 0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1);
    idle(40);
    checkInt("zero_ndrop", drop_q.size(), 0);
    checkInt("zero_ndone", done_q.size(), 2);
    checkInt("zero_lit", lit_cnt, 12);

    $display("[TB] chaining");
    clearStats();
    base = cyc;
    idle(10);
    applyStimulus(1'b0, 1'b1, 2);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1);
    idle(30);
    checkInt("chain_ndone", done_q.size(), 2);
    if (done_q.size() == 2) begin
      checkInt("chain_done1", done_q[0] - base, 27);
      checkInt("chain_done2", done_q[1] - base, 35);
    end

    $display("[TB] overflow");
    clearStats();
    base = cyc;
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 5);
    idle(40);
    checkInt("ovf_ndrop", drop_q.size(), 1);
    if (drop_q.size() == 1) checkInt("ovf_drop_cyc", drop_q[0] - base, 3);
    checkInt("ovf_ndone", done_q.size(), 2);
    checkInt("ovf_lit", lit_cnt, 12);

    $display("[TB] requests in the last OFF cycle");
    clearStats();
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 2);
    idle(6);
    applyStimulus(1'b0, 1'b1, 3);
    idle(50);
    checkInt("last_ndrop", drop_q.size(), 0);
    checkInt("last_ndone", done_q.size(), 3);
    if (done_q.size() == 3) begin
      checkInt("last_done1", done_q[0] - base, 9);
      checkInt("last_done2", done_q[1] - base, 25);
      checkInt("last_done3", done_q[2] - base, 49);
    end

    $display("[TB] reset mid-sequence");
    clearStats();
    base = cyc;
    idle(10);
    applyStimulus(1'b0, 1'b1, 3);
    idle(4);
    applyStimulus(1'b1, 1'b0, 0);
    idle(20);
    checkInt("rst_ndone", done_q.size(), 0);
    clearStats();
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1);
    idle(12);
    checkInt("rst_fresh_lit", lit_cnt, 4);
    checkInt("rst_fresh_ndone", done_q.size(), 1);
    if (done_q.size() == 1) checkInt("rst_fresh_done", done_q[0] - (base + 1), 8);

    $display("[TB] random requests");
    for (int i = 0; i < 800; i++) begin
      bit r, q;
      int n;
      r = ($urandom_range(0, 249) == 0);
      q = ($urandom_range(0, 7) == 0);
      n = $urandom_range(0, 3);
      applyStimulus(r, q, n);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
